// File: rtl/pmux_rr_pkg.sv
// Shared types and helpers for the pmux round-robin select generator.
// State encoding and index-width computation used by all pmux_rr files.
package pmux_rr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmux_rr_pick.sv
// Round-robin winner finder: rotate requests by the pointer, take the
// lowest set bit, then map the offset back to an absolute index.
module pmux_rr_pick
    import pmux_rr_pkg::*;
#(
    parameter int S_WIDTH   = 4,
    parameter int IDX_WIDTH = idx_width(S_WIDTH)
) (
    input  logic [S_WIDTH-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] win,
    output logic                 found
);

    logic [2*S_WIDTH-1:0] dbl;
    logic [S_WIDTH-1:0]   rot;
    logic [IDX_WIDTH-1:0] off;
    int                   sum;

    // Rotate so ptr lands at bit 0, find first set bit, un-rotate.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[S_WIDTH-1:0];
        off = '0;
        for (int i = S_WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_WIDTH'(i);
        end
        found = |rot;
        sum = int'(off) + int'(ptr);
        if (sum >= S_WIDTH) sum = sum - S_WIDTH;
        win = IDX_WIDTH'(sum);
    end

endmodule

// File: rtl/pmux_rr_select.sv
// Registered one-hot round-robin select for a downstream parallel mux.
// Optional forced release after MAX_HOLD cycles: PMUX_RR_SELECT_TIMEOUT_EN.
module pmux_rr_select
    import pmux_rr_pkg::*;
#(
    parameter int S_WIDTH    = 4,
    parameter int HOLD_WIDTH = 8,
    parameter int MAX_HOLD   = 16,
    localparam int IDX_WIDTH = idx_width(S_WIDTH)
) (
    input  logic                 CLK,
    input  logic                 SRST,
    input  logic [S_WIDTH-1:0]   REQ,
    input  logic                 DONE,
    output logic [S_WIDTH-1:0]   S,
    output logic                 BUSY,
    output logic [IDX_WIDTH-1:0] IDX,
    output logic                 TIMEOUT
);

    state_t               state, state_n;
    logic [S_WIDTH-1:0]   s_q, s_n;
    logic [IDX_WIDTH-1:0] idx_q, idx_n;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_n;
    logic                 to_q, to_n;
    logic [IDX_WIDTH-1:0] win, ptr_inc;
    logic                 found, rel;
`ifdef PMUX_RR_SELECT_TIMEOUT_EN
    logic [HOLD_WIDTH-1:0] hold_q, hold_n;
`endif

    pmux_rr_pick #(
        .S_WIDTH   (S_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .win   (win),
        .found (found)
    );

    assign ptr_inc = (int'(win) == S_WIDTH - 1) ? '0 : win + 1'b1;

    // Next state: decide release, then arbitrate on any release.
    always_comb begin
        state_n = state;
        s_n     = s_q;
        idx_n   = idx_q;
        ptr_n   = ptr_q;
        to_n    = 1'b0;
        rel     = 1'b0;
`ifdef PMUX_RR_SELECT_TIMEOUT_EN
        hold_n  = hold_q;
`endif
        unique case (state)
            ST_IDLE: rel = 1'b1;
            ST_GRANT: begin
                if (DONE) rel = 1'b1;
`ifdef PMUX_RR_SELECT_TIMEOUT_EN
                else if (hold_q == HOLD_WIDTH'(MAX_HOLD - 1)) begin
                    rel  = 1'b1;
                    to_n = 1'b1;
                end
                else hold_n = hold_q + 1'b1;
`endif
            end
            default: rel = 1'b0;
        endcase
        if (rel) begin
            if (found) begin
                state_n = ST_GRANT;
                s_n     = S_WIDTH'(1) << win;
                idx_n   = win;
                ptr_n   = ptr_inc;
`ifdef PMUX_RR_SELECT_TIMEOUT_EN
                hold_n  = '0;
`endif
            end else begin
                state_n = ST_IDLE;
                s_n     = '0;
            end
        end
    end

    // State, grant and pointer registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (SRST) begin
            state <= ST_IDLE;
            s_q   <= '0;
            idx_q <= '0;
            ptr_q <= '0;
            to_q  <= 1'b0;
        end else begin
            state <= state_n;
            s_q   <= s_n;
            idx_q <= idx_n;
            ptr_q <= ptr_n;
            to_q  <= to_n;
        end
    end

`ifdef PMUX_RR_SELECT_TIMEOUT_EN
    // Hold counter, cleared on each new grant.
    always_ff @(posedge CLK) begin
        if (SRST) hold_q <= '0;
        else      hold_q <= hold_n;
    end
`endif

    assign S       = s_q;
    assign BUSY    = |s_q;
    assign IDX     = idx_q;
    assign TIMEOUT = to_q;

endmodule

// File: tb/tb_pmux_rr_select.sv
// Testbench for pmux_rr_select: directed steps plus random traffic,
// checked against an arithmetic round-robin reference model.
module tb_pmux_rr_select;

    localparam int SW = 4;
    localparam int MH = 3;
`ifdef PMUX_RR_SELECT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          SRST = 1'b1;
    logic [SW-1:0] REQ = '0;
    logic          DONE = 1'b0;
    logic [SW-1:0] S;
    logic          BUSY;
    logic [1:0]    IDX;
    logic          TIMEOUT;

    int n_cmp = 0;
    int n_bad = 0;

    int m_busy = 0;
    int m_idx  = 0;
    int m_ptr  = 0;
    int m_hold = 0;
    int m_to   = 0;

    pmux_rr_select #(
        .S_WIDTH    (SW),
        .HOLD_WIDTH (8),
        .MAX_HOLD   (MH)
    ) dut (
        .CLK     (CLK),
        .SRST    (SRST),
        .REQ     (REQ),
        .DONE    (DONE),
        .S       (S),
        .BUSY    (BUSY),
        .IDX     (IDX),
        .TIMEOUT (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [SW-1:0] req, input logic done,
                              input logic srst);
        bit rel;
        bit to;
        int w;
        if (srst) begin
            m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
        end else begin
            rel = 0;
            to  = 0;
            if (m_busy == 0) rel = 1;
            else if (done) rel = 1;
            else if (TO_EN && m_hold == MH - 1) begin
                rel = 1;
                to  = 1;
            end else m_hold++;
            if (rel) begin
                w = -1;
                for (int k = 0; k < SW; k++) begin
                    if (w < 0 && req[(m_ptr + k) % SW]) w = (m_ptr + k) % SW;
                end
                if (w >= 0) begin
                    m_busy = 1;
                    m_idx  = w;
                    m_ptr  = (w + 1) % SW;
                    m_hold = 0;
                end else begin
                    m_busy = 0;
                end
            end
            m_to = to;
        end
    endtask

    task automatic step(input logic [SW-1:0] req, input logic done,
                        input logic srst);
        logic [SW-1:0] exp_s;
        REQ  = req;
        DONE = done;
        SRST = srst;
        @(posedge CLK);
        model_step(req, done, srst);
        #1;
        exp_s = m_busy ? SW'(1) << m_idx : '0;
        check("model_S", 32'(S), 32'(exp_s));
        check("model_BUSY", 32'(BUSY), 32'(m_busy));
        check("model_IDX", 32'(IDX), 32'(m_idx));
        check("model_TIMEOUT", 32'(TIMEOUT), 32'(m_to));
    endtask

    logic [SW-1:0] fair_exp [5];
    logic [SW-1:0] r;

    initial begin
        fair_exp[0] = 4'b0001;
        fair_exp[1] = 4'b0010;
        fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000;
        fair_exp[4] = 4'b0001;

        // reset with all inputs active
        step(4'b1111, 1'b1, 1'b1);
        check("rst_S", 32'(S), 32'h0);
        check("rst_BUSY", 32'(BUSY), 32'h0);
        check("rst_IDX", 32'(IDX), 32'h0);
        check("rst_TIMEOUT", 32'(TIMEOUT), 32'h0);

        // basic grant then back-to-back
        step(4'b0101, 1'b0, 1'b0);
        check("basic_S", 32'(S), 32'h1);
        check("basic_IDX", 32'(IDX), 32'h0);
        step(4'b0101, 1'b1, 1'b0);
        check("b2b_S", 32'(S), 32'h4);
        check("b2b_IDX", 32'(IDX), 32'h2);

        // fairness
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        check("fair_0", 32'(S), 32'(fair_exp[0]));
        for (int i = 1; i < 5; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            check($sformatf("fair_%0d", i), 32'(S), 32'(fair_exp[i]));
        end

        // request drop mid-grant
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b0);
        check("drop_grant", 32'(S), 32'h2);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b0, 1'b0);
            check("drop_hold", 32'(S), 32'h2);
        end
        step(4'b0000, 1'b1, 1'b0);
        check("drop_rel_S", 32'(S), 32'h0);
        check("drop_rel_BUSY", 32'(BUSY), 32'h0);
        step(4'b1111, 1'b0, 1'b0);
        check("drop_ptr", 32'(S), 32'h4);

        // reset mid-grant
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b0);
        check("midrst_pre", 32'(S), 32'h8);
        step(4'b1111, 1'b1, 1'b1);
        check("midrst_S", 32'(S), 32'h0);
        step(4'b1111, 1'b0, 1'b0);
        check("midrst_next", 32'(S), 32'h1);

        // hold timeout behaviour
        step(4'b0000, 1'b0, 1'b1);
`ifdef PMUX_RR_SELECT_TIMEOUT_EN
        for (int i = 0; i < MH; i++) begin
            step(4'b0001, 1'b0, 1'b0);
            check("to_hold_S", 32'(S), 32'h1);
            check("to_hold_TO", 32'(TIMEOUT), 32'h0);
        end
        step(4'b0001, 1'b0, 1'b0);
        check("to_fire_TO", 32'(TIMEOUT), 32'h1);
        check("to_fire_S", 32'(S), 32'h1);
        step(4'b0001, 1'b0, 1'b0);
        check("to_pulse_end", 32'(TIMEOUT), 32'h0);
`else
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 1'b0, 1'b0);
            check("noto_S", 32'(S), 32'h1);
            check("noto_TO", 32'(TIMEOUT), 32'h0);
        end
`endif

        // random traffic against the model
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            r = SW'($urandom);
            step(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
